// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- asynchronous serial receiver (8N1, or 8E1 with UART_RX_PARITY_EN)
//
// Recovers bytes from an idle-high serial line and presents them on a
// valid/ready output port. The line is synchronized, a falling edge starts a
// frame, and each bit is sampled near its centre using a down-counting timer.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   -> 8E1 frames, an extra PARITY state checks even parity
//   undefined -> 8N1 frames, no parity logic
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rstn       in   1  asynchronous active-low reset
//   rx         in   1  serial line, idle high, asynchronous to clk
//   data       out  8  received byte, stable while valid=1
//   valid      out  1  data holds an unconsumed byte
//   ready      in   1  consumer accepts data when valid & ready
//   frame_err  out  1  one-cycle pulse: bad stop bit (or bad parity)
//   overrun    out  1  one-cycle pulse: byte committed while valid & !ready
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 115200,
    parameter int DIVISOR  = CLK_FREQ / BAUD,
    parameter int HALF     = DIVISOR / 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int              TW          = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
    localparam logic [TW-1:0]   DIV_RELOAD  = TW'(DIVISOR - 1);
    localparam logic [TW-1:0]   HALF_RELOAD = TW'(HALF - 1);
    localparam logic [TW-1:0]   TIMER_ZERO  = TW'(0);
    localparam logic [TW-1:0]   TIMER_ONE   = TW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data and parity bit must be zero.
    function automatic logic parity_ok(input logic [7:0] d, input logic p);
        return (^{d, p}) == 1'b0;
    endfunction
`endif

    logic          rx_meta_r;
    logic          rx_sync_r;   // synchronized line (rx_s)
    logic          rx_d_r;      // rx_sync_r delayed one cycle (rx_d)
    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
`ifdef UART_RX_PARITY_EN
    logic          parity_r;
`endif
    logic          timer_done_s;
    logic          frame_good_s;

    // Two-flop synchronizer plus one delay stage for start-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_d_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_d_r    <= rx_sync_r;
        end
    end

    // Timer expiry and stop-sample frame acceptance.
    always_comb begin
        timer_done_s = (timer_r == TIMER_ZERO);
`ifdef UART_RX_PARITY_EN
        frame_good_s = rx_sync_r & parity_ok(shift_r, parity_r);
`else
        frame_good_s = rx_sync_r;
`endif
    end

    // Receive FSM, shift register and registered output port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            timer_r   <= TIMER_ZERO;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_r  <= 1'b0;
`endif
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // Consumption; a commit in the same cycle overrides this below.
            if (valid && ready) begin
                valid <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    // Requiring rx_d high means a held-low line (break) must
                    // return high before the next frame can start.
                    if (rx_d_r && !rx_sync_r) begin
                        state_r <= ST_START;
                        timer_r <= HALF_RELOAD;
                    end
                end
                ST_START: begin
                    if (timer_done_s) begin
                        if (!rx_sync_r) begin
                            state_r   <= ST_DATA;
                            timer_r   <= DIV_RELOAD;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            // Start bit not held: treat the edge as a glitch.
                            state_r <= ST_IDLE;
                            timer_r <= TIMER_ZERO;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                ST_DATA: begin
                    if (timer_done_s) begin
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        timer_r <= DIV_RELOAD;
                        if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (timer_done_s) begin
                        parity_r <= rx_sync_r;
                        timer_r  <= DIV_RELOAD;
                        state_r  <= ST_STOP;
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (timer_done_s) begin
                        // Return to IDLE mid-stop-bit so back-to-back frames fit.
                        state_r <= ST_IDLE;
                        timer_r <= TIMER_ZERO;
                        if (frame_good_s) begin
                            data    <= shift_r;
                            valid   <= 1'b1;
                            overrun <= valid & ~ready;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r - TIMER_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= TIMER_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx at default parameters.
// Bytes expected at the output port are queued when their frame is driven and
// popped by a monitor whenever valid & ready is observed.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DIV = 12_000_000 / 115200;  // 104 cycles per bit

    logic       clk;
    logic       rstn;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;

    int nvec = 0;
    int nerr = 0;
    int got_cnt = 0;
    int valid_cycles = 0;
    int fe_cycles = 0;
    int ov_cycles = 0;
    logic [7:0] q[$];
    logic [7:0] exp_b;
`ifdef UART_RX_PARITY_EN
    logic par_flip = 1'b0;
`endif

    uart_rx dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts output activity and scores every consumed byte.
    always @(negedge clk) begin
        if (rstn) begin
            if (valid) valid_cycles++;
            if (frame_err) fe_cycles++;
            if (overrun) ov_cycles++;
            if (valid && ready) begin
                nvec++;
                got_cnt++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_byte: got %h, required no byte", data);
                end else begin
                    exp_b = q.pop_front();
                    if (data !== exp_b) begin
                        nerr++;
                        $display("FAIL byte_value: got %h, required %h", data, exp_b);
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle_cycles(DIV);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            idle_cycles(DIV);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        idle_cycles(DIV);
`endif
        rx = stop_bit;
        idle_cycles(DIV);
    endtask

    // Bounded wait for the scoreboard queue to empty.
    task automatic wait_drain();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; rx = 1'b1; ready = 1'b1;
        idle_cycles(3);
        nvec++; if (data !== 8'h00) begin nerr++; $display("FAIL reset_data: got %h, required 00", data); end
        nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b, required 0", valid); end
        nvec++; if (frame_err !== 1'b0) begin nerr++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
        nvec++; if (overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
        rstn = 1'b1;
        idle_cycles(10);
        nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL idle_valid: got %b, required 0", valid); end
    endtask

    task automatic test_single();
        int vc0 = valid_cycles, fe0 = fe_cycles, ov0 = ov_cycles, g0 = got_cnt;
        q.push_back(8'h56);
        send_frame(8'h56, 1'b1);
        wait_drain();
        idle_cycles(20);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL single_drain: got %0d pending, required 0", q.size()); end
        nvec++; if (got_cnt - g0 != 1) begin nerr++; $display("FAIL single_count: got %0d, required 1", got_cnt - g0); end
        nvec++; if (valid_cycles - vc0 != 1) begin nerr++; $display("FAIL single_valid_width: got %0d, required 1", valid_cycles - vc0); end
        nvec++; if (fe_cycles != fe0 || ov_cycles != ov0) begin nerr++; $display("FAIL single_errors: got fe=%0d ov=%0d, required 0 0", fe_cycles - fe0, ov_cycles - ov0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [11] = '{8'h56, 8'h61, 8'h6C, 8'h75, 8'h65, 8'h3A, 8'h20, 8'h31, 8'h30, 8'h31, 8'h0A};
        int fe0 = fe_cycles, ov0 = ov_cycles, g0 = got_cnt;
        for (int i = 0; i < 11; i++) begin
            q.push_back(msg[i]);
            send_frame(msg[i], 1'b1);
        end
        wait_drain();
        idle_cycles(20);
        nvec++; if (got_cnt - g0 != 11) begin nerr++; $display("FAIL b2b_count: got %0d, required 11", got_cnt - g0); end
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL b2b_drain: got %0d pending, required 0", q.size()); end
        nvec++; if (fe_cycles != fe0 || ov_cycles != ov0) begin nerr++; $display("FAIL b2b_errors: got fe=%0d ov=%0d, required 0 0", fe_cycles - fe0, ov_cycles - ov0); end
    endtask

    task automatic test_glitch();
        int vc0 = valid_cycles, fe0 = fe_cycles;
        rx = 1'b0;
        idle_cycles(20);
        rx = 1'b1;
        idle_cycles(3 * DIV);
        nvec++; if (valid_cycles != vc0) begin nerr++; $display("FAIL glitch_no_valid: got %0d valid cycles, required 0", valid_cycles - vc0); end
        nvec++; if (fe_cycles != fe0) begin nerr++; $display("FAIL glitch_no_ferr: got %0d, required 0", fe_cycles - fe0); end
        q.push_back(8'h31);
        send_frame(8'h31, 1'b1);
        wait_drain();
        idle_cycles(5);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL glitch_recover: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_frame_err();
        int vc0 = valid_cycles, fe0 = fe_cycles;
        send_frame(8'hA5, 1'b0);
        rx = 1'b1;
        idle_cycles(2 * DIV);
        nvec++; if (fe_cycles - fe0 != 1) begin nerr++; $display("FAIL ferr_pulse: got %0d cycles, required 1", fe_cycles - fe0); end
        nvec++; if (valid_cycles != vc0) begin nerr++; $display("FAIL ferr_no_valid: got %0d valid cycles, required 0", valid_cycles - vc0); end
        q.push_back(8'h30);
        send_frame(8'h30, 1'b1);
        wait_drain();
        idle_cycles(5);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL ferr_recover: got %0d pending, required 0", q.size()); end
    endtask

    task automatic test_overrun();
        int ov0 = ov_cycles;
        @(posedge clk); #1 ready = 1'b0;
        send_frame(8'h31, 1'b1);
        nvec++; if (data !== 8'h31 || valid !== 1'b1) begin nerr++; $display("FAIL ovr_first: got %h/%b, required 31/1", data, valid); end
        nvec++; if (ov_cycles != ov0) begin nerr++; $display("FAIL ovr_none_first: got %0d, required 0", ov_cycles - ov0); end
        send_frame(8'h3A, 1'b1);
        nvec++; if (ov_cycles - ov0 != 1) begin nerr++; $display("FAIL ovr_pulse: got %0d cycles, required 1", ov_cycles - ov0); end
        nvec++; if (data !== 8'h3A || valid !== 1'b1) begin nerr++; $display("FAIL ovr_data: got %h/%b, required 3a/1", data, valid); end
        q.push_back(8'h3A);
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        @(negedge clk);
        nvec++; if (valid !== 1'b0) begin nerr++; $display("FAIL ovr_consume: got %b, required 0", valid); end
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL ovr_popped: got %0d pending, required 0", q.size()); end
        @(posedge clk); #1 ready = 1'b1;
    endtask

    task automatic test_reset_midframe();
        int vc0;
        rx = 1'b0;
        idle_cycles(DIV);
        for (int k = 0; k < 4; k++) begin
            rx = k[0];
            idle_cycles(DIV);
        end
        rx = 1'b0;
        idle_cycles(DIV / 2);
        rstn = 1'b0;
        rx = 1'b1;
        idle_cycles(3);
        nvec++; if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            nerr++; $display("FAIL mid_reset_outputs: got %h/%b/%b/%b, required 00/0/0/0", data, valid, frame_err, overrun);
        end
        rstn = 1'b1;
        vc0 = valid_cycles;
        idle_cycles(12 * DIV);
        nvec++; if (valid_cycles != vc0) begin nerr++; $display("FAIL mid_reset_no_valid: got %0d valid cycles, required 0", valid_cycles - vc0); end
        q.push_back(8'h65);
        send_frame(8'h65, 1'b1);
        wait_drain();
        idle_cycles(5);
        nvec++; if (q.size() != 0) begin nerr++; $display("FAIL mid_reset_recover: got %0d pending, required 0", q.size()); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int vc0 = valid_cycles, fe0 = fe_cycles;
        par_flip = 1'b1;
        send_frame(8'h65, 1'b1);
        par_flip = 1'b0;
        idle_cycles(DIV);
        nvec++; if (fe_cycles - fe0 != 1) begin nerr++; $display("FAIL parity_ferr: got %0d cycles, required 1", fe_cycles - fe0); end
        nvec++; if (valid_cycles != vc0) begin nerr++; $display("FAIL parity_no_valid: got %0d valid cycles, required 0", valid_cycles - vc0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the 12 MHz iCEZum designs: recovers 8N1 (optionally 8E1) frames from an asynchronous serial line and presents each byte on a valid/ready output port. It is the receiving end of the team's `uart_tx` message transmitter. It sits between the board's RX pin and any consumer logic, such as a command parser, a FIFO or a loopback checker.

## Interface
Parameters:
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line bit rate.
- `DIVISOR`, `CLK_FREQ/BAUD` (truncated, 104 at defaults): clock cycles per bit.
- `HALF`, `DIVISOR/2` (52 at defaults): cycles from start edge to start-bit mid-sample.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `data`  out  8  received byte, stable while `valid`=1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` when `valid`&`ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low (or parity mismatch, see Configuration).
- `overrun`  out  1  one-cycle pulse: new byte completed while `valid`=1 and `ready`=0.

## Operation
- `rx` passes through a 2-FF synchronizer, reset to 1. `rx_s` is the synchronized value; `rx_d` is `rx_s` delayed one cycle.
- Bit timer: a counter sized for `DIVISOR-1`, reloaded at every state entry.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the parity macro is enabled).
  - IDLE: a start edge is `rx_d`=1 & `rx_s`=0. Go to START, timer counts `HALF`.
  - START: at timer expiry, sample `rx_s`. If 0, go to DATA. If 1, the edge was a glitch: return to IDLE, no outputs change.
  - DATA: sample every `DIVISOR` cycles. 8 samples, shifted in LSB first (first data bit → `data[0]`). After the 8th sample go to STOP, or to PARITY if enabled.
  - STOP: one `DIVISOR` interval, then sample.
    - Sample 1: commit the byte.
    - Sample 0: pulse `frame_err` and discard the byte.
    - Either way go to IDLE.
- After a low stop bit (break), IDLE needs `rx_s` to return high before a new edge is accepted. The edge rule enforces this by construction.
- Commit rules (output register is separate from the shift register):
  - `valid`=0: load `data`, set `valid`.
  - `valid`=1 & `ready`=1 in the same cycle: old byte is consumed, new byte is loaded, `valid` stays 1, no `overrun`.
  - `valid`=1 & `ready`=0: overwrite `data`, `valid` stays 1, pulse `overrun`.
- `valid`&`ready` with no commit: clear `valid` next edge.
- `ready` is ignored while `valid`=0.
- Reset (any time, including mid-frame):
  - FSM → IDLE, shift register and timer cleared.
  - `data`=8'h00, `valid`=0, `frame_err`=0, `overrun`=0.
  - Synchronizer FFs = 1.

## Timing
- Input latency: 2 cycles through the synchronizer, plus 1 cycle for edge detection.
- Cycle E is the edge-detect cycle. Start sample at E+`HALF`. Data bit k sample at E+`HALF`+(k+1)·`DIVISOR`, for k=0..7. Stop sample at E+`HALF`+9·`DIVISOR` (+`DIVISOR` with parity).
- `valid` rises, `frame_err` pulses and `overrun` pulses on the edge immediately after the stop sample.
- Back-to-back frames are accepted: IDLE is re-entered right after the stop sample, about `HALF` cycles before the nominal stop-bit end.
- Tolerates ±2% baud mismatch at defaults. Truncation of `DIVISOR` contributes 0.16%.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame is 8E1. The PARITY state samples one extra bit after the data bits. At the stop sample, the byte is committed only if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 0. Otherwise `frame_err` pulses and the byte is discarded.
- Not defined: the frame is 8N1. No PARITY state and no parity logic is synthesized.

## Test plan
- Single byte 0x56 at 104 cycles/bit, `ready`=1 → `data`=0x56, `valid` high 1 cycle, `frame_err`=0, `overrun`=0.
- 11 back-to-back bytes "Value: 101\n" (0x56 … 0x0A), `ready`=1 → 11 `valid` pulses with bytes in order, no errors.
- `rx` low for 20 cycles, then high → no `valid`, FSM back in IDLE; a following 0x31 frame is received correctly.
- Frame 0xA5 with stop bit driven 0 → `frame_err` 1-cycle pulse, `valid` stays 0; after `rx` returns high, 0x30 is received.
- `ready`=0, bytes 0x31 then 0x3A → `overrun` pulse at the second stop sample, `data`=0x3A, `valid`=1. Then `ready`=1 for one cycle → `valid`=0.
- `rstn` pulsed low during bit 4 of a frame → all outputs at reset values, no `valid`; the next full frame 0x65 is received. With `UART_RX_PARITY_EN`, 0x65 sent with wrong parity → `frame_err`.
